bm_arbiter: RTL and testbench

- Sole owner of the block-map command port (bm_enable/bm_func/bm_row/bm_col/bm_stage).
- Two command sources share the port:
  - Stage loads from the game state machine.
  - Block-clear requests from every ball/shot collision detector.
- Clear requests are round-robin arbitrated into a small deduplicating FIFO, then issued one at a time, gated by bm_ready.
- Loads take priority over clears and flush any pending clears.

---
 rtl/bm_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_bm_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bm_arbiter.sv
// Block-map command port owner: merges stage loads and round-robin arbitrated,
// deduplicated block-clear requests into one handshaked command stream.

package bm_arbiter_pkg;
    localparam logic [1:0] F_LOAD  = 2'd1;
    localparam logic [1:0] F_CLEAR = 2'd2;

    typedef struct packed {
        logic [4:0] row;
        logic [4:0] col;
    } bm_coord_t;
endpackage

module bm_arbiter #(
    parameter int unsigned REQ_NUM    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_req,
    input  logic [1:0]           load_stage,
    output logic                 load_ack,
    input  logic [REQ_NUM-1:0]   clr_req,
    input  logic [REQ_NUM*5-1:0] clr_row,
    input  logic [REQ_NUM*5-1:0] clr_col,
    output logic [REQ_NUM-1:0]   clr_ack,
    input  logic                 bm_ready,
    output logic                 bm_enable,
    output logic [1:0]           bm_func,
    output logic [4:0]           bm_row,
    output logic [4:0]           bm_col,
    output logic [1:0]           bm_stage,
    output logic                 busy
);
    import bm_arbiter_pkg::*;

    localparam int unsigned COORD_W = 5;
    localparam int unsigned IDX_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PTR_W   = IDX_W + 1;
    localparam int unsigned RR_W    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GUARD = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [1:0]      cmd_func;
    logic [1:0]      cmd_stage;
    bm_coord_t       cmd_coord;

    bm_coord_t       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] fifo_count;
    logic            fifo_empty;
    logic            fifo_full;

    logic [RR_W-1:0] rr_ptr;
    logic [RR_W-1:0] sel_idx;
    logic [RR_W-1:0] cand;
    logic            sel_found;
    bm_coord_t       sel_coord;
    bm_coord_t       req_coord [REQ_NUM];

    logic [IDX_W-1:0] slot_off;
    logic            dup_fifo;
    logic            dup_flight;
    logic            dup;
    logic            accept;
    logic            push;

    logic            issue_load;
    logic            issue_pop;
    logic            issue_byp;

    // Unpack per-requester coordinates
    for (genvar g = 0; g < REQ_NUM; g++) begin : g_req
        assign req_coord[g] = {clr_row[g*COORD_W +: COORD_W], clr_col[g*COORD_W +: COORD_W]};
    end

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                        (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

    // Round-robin scan starting at rr_ptr
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < REQ_NUM; k++) begin
            cand = RR_W'((32'(rr_ptr) + k) % REQ_NUM);
            if (!sel_found && clr_req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign sel_coord = req_coord[sel_idx];

    // Match against every valid queued entry
    always_comb begin
        dup_fifo = 1'b0;
        slot_off = '0;
        for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
            slot_off = IDX_W'(j) - rd_ptr[IDX_W-1:0];
            if (({1'b0, slot_off} < fifo_count) && (fifo_mem[j] == sel_coord)) begin
                dup_fifo = 1'b1;
            end
        end
    end

    assign dup_flight = (state != S_IDLE) && (cmd_func == F_CLEAR) && (cmd_coord == sel_coord);
    assign dup        = dup_fifo || dup_flight;
    assign accept     = !reset && sel_found && !load_req && (dup || !fifo_full);
    assign push       = accept && !dup && !issue_byp;

    always_comb begin
        clr_ack = '0;
        if (accept) begin
            clr_ack[sel_idx] = 1'b1;
        end
    end

    // Command sequencer: next state and issue decision
    always_comb begin
        state_nxt  = state;
        issue_load = 1'b0;
        issue_pop  = 1'b0;
        issue_byp  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bm_ready) begin
                    if (load_req) begin
                        issue_load = 1'b1;
                        state_nxt  = S_ISSUE;
                    end else if (!fifo_empty) begin
                        issue_pop = 1'b1;
                        state_nxt = S_ISSUE;
                    end else if (accept) begin
                        issue_byp = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_nxt = S_GUARD;
            S_GUARD: state_nxt = S_WAIT;
            S_WAIT:  if (bm_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd_func  <= 2'd0;
            cmd_stage <= 2'd0;
            cmd_coord <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rr_ptr    <= '0;
        end else begin
            state <= state_nxt;

            if (issue_load) begin
                cmd_func  <= F_LOAD;
                cmd_stage <= load_stage;
            end else if (issue_pop) begin
                cmd_func  <= F_CLEAR;
                cmd_coord <= fifo_mem[rd_ptr[IDX_W-1:0]];
            end else if (issue_byp) begin
                cmd_func  <= F_CLEAR;
                cmd_coord <= sel_coord;
            end

            // A load discards everything still queued
            if (issue_load) begin
                rd_ptr <= wr_ptr;
            end else if (issue_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            if (accept) begin
                rr_ptr <= (32'(sel_idx) == REQ_NUM - 1) ? '0 : sel_idx + RR_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr[IDX_W-1:0]] <= sel_coord;
        end
    end

    assign bm_enable = (state == S_ISSUE);
    assign load_ack  = (state == S_ISSUE) && (cmd_func == F_LOAD);
    assign bm_func   = cmd_func;
    assign bm_row    = cmd_coord.row;
    assign bm_col    = cmd_coord.col;
    assign bm_stage  = cmd_stage;
    assign busy      = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_bm_arbiter.sv
// Directed bench for bm_arbiter: clears, dedup, full FIFO, load flush, async reset.

module tb_bm_arbiter;
    import bm_arbiter_pkg::*;

    localparam int unsigned REQ_NUM    = 4;
    localparam int unsigned FIFO_DEPTH = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 load_req;
    logic [1:0]           load_stage;
    logic                 load_ack;
    logic [REQ_NUM-1:0]   clr_req;
    logic [REQ_NUM*5-1:0] clr_row;
    logic [REQ_NUM*5-1:0] clr_col;
    logic [REQ_NUM-1:0]   clr_ack;
    logic                 bm_ready;
    logic                 bm_enable;
    logic [1:0]           bm_func;
    logic [4:0]           bm_row;
    logic [4:0]           bm_col;
    logic [1:0]           bm_stage;
    logic                 busy;

    logic [4:0] row_a [REQ_NUM];
    logic [4:0] col_a [REQ_NUM];

    int checks = 0;
    int fails  = 0;
    int n_en   = 0;

    for (genvar g = 0; g < REQ_NUM; g++) begin : g_pack
        assign clr_row[g*5 +: 5] = row_a[g];
        assign clr_col[g*5 +: 5] = col_a[g];
    end

    bm_arbiter #(.REQ_NUM(REQ_NUM), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_req   (load_req),
        .load_stage (load_stage),
        .load_ack   (load_ack),
        .clr_req    (clr_req),
        .clr_row    (clr_row),
        .clr_col    (clr_col),
        .clr_ack    (clr_ack),
        .bm_ready   (bm_ready),
        .bm_enable  (bm_enable),
        .bm_func    (bm_func),
        .bm_row     (bm_row),
        .bm_col     (bm_col),
        .bm_stage   (bm_stage),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        load_req   = 1'b0;
        load_stage = 2'd0;
        clr_req    = '0;
        bm_ready   = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) begin
            row_a[i] = '0;
            col_a[i] = '0;
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        chk("rst_en", 32'(bm_enable), 0);
        chk("rst_func", 32'(bm_func), 0);
        chk("rst_row", 32'(bm_row), 0);
        chk("rst_col", 32'(bm_col), 0);
        chk("rst_stage", 32'(bm_stage), 0);
        chk("rst_lack", 32'(load_ack), 0);
        chk("rst_cack", 32'(clr_ack), 0);
        chk("rst_busy", 32'(busy), 0);

        // Single clear with empty FIFO: ack in cycle 0, issue in cycle 1
        tick(); bm_ready = 1'b1; clr_req = 4'b0001; row_a[0] = 5'd3; col_a[0] = 5'd5; #1;
        chk("t1_ack", 32'(clr_ack), 32'h1);
        chk("t1_en_c0", 32'(bm_enable), 0);
        tick(); clr_req = '0; #1;
        chk("t1_en_c1", 32'(bm_enable), 1);
        chk("t1_func", 32'(bm_func), 32'(F_CLEAR));
        chk("t1_row", 32'(bm_row), 3);
        chk("t1_col", 32'(bm_col), 5);
        chk("t1_busy_c1", 32'(busy), 1);
        tick(); #1;
        chk("t1_en_c2", 32'(bm_enable), 0);
        tick(); #1;
        chk("t1_busy_c3", 32'(busy), 1);
        tick(); #1;
        chk("t1_busy_c4", 32'(busy), 0);

        // Four requesters fill the FIFO while the block map is busy
        do_reset();
        for (int i = 0; i < REQ_NUM; i++) begin
            row_a[i] = 5'(10 + i);
            col_a[i] = 5'(20 + i);
        end
        for (int k = 0; k < 4; k++) begin
            tick(); clr_req = 4'(4'b1111 << k); #1;
            chk("t2_ack_fill", 32'(clr_ack), 32'(1) << k);
            chk("t2_en_fill", 32'(bm_enable), 0);
        end
        tick(); clr_req = 4'b0001; row_a[0] = 5'd30; col_a[0] = 5'd30; #1;
        chk("t2_full_noack", 32'(clr_ack), 0);
        chk("t2_busy", 32'(busy), 1);
        tick(); clr_req = '0; bm_ready = 1'b1; #1;
        chk("t2_en_c5", 32'(bm_enable), 0);
        for (int c = 6; c <= 21; c++) begin
            tick(); #1;
            if ((c - 6) % 4 == 0) begin
                chk("t2_en_issue", 32'(bm_enable), 1);
                chk("t2_row", 32'(bm_row), 32'(10 + (c - 6) / 4));
                chk("t2_col", 32'(bm_col), 32'(20 + (c - 6) / 4));
            end else begin
                chk("t2_en_gap", 32'(bm_enable), 0);
            end
        end
        chk("t2_busy_end", 32'(busy), 0);

        // Requester 2 holds the coordinate of its own in-flight clear
        do_reset();
        row_a[2] = 5'd7; col_a[2] = 5'd1;
        n_en = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            bm_ready = (c == 0) || (c >= 6);
            clr_req  = (c <= 5) ? 4'b0100 : 4'b0000;
            #1;
            chk("t3_ack", 32'(clr_ack), (c <= 5) ? 32'h4 : 32'h0);
            if (bm_enable) n_en++;
            if (c == 1) begin
                chk("t3_func", 32'(bm_func), 32'(F_CLEAR));
                chk("t3_row", 32'(bm_row), 7);
                chk("t3_col", 32'(bm_col), 1);
            end
        end
        chk("t3_issue_count", 32'(n_en), 1);
        chk("t3_busy_end", 32'(busy), 0);

        // Three queued clears, then a load flushes them
        do_reset();
        row_a[0] = 5'd1; col_a[0] = 5'd2;
        row_a[1] = 5'd3; col_a[1] = 5'd4;
        row_a[3] = 5'd5; col_a[3] = 5'd6;
        tick(); clr_req = 4'b1011; #1;
        chk("t4_ack0", 32'(clr_ack), 32'h1);
        tick(); clr_req = 4'b1010; #1;
        chk("t4_ack1", 32'(clr_ack), 32'h2);
        tick(); clr_req = 4'b1000; #1;
        chk("t4_ack3", 32'(clr_ack), 32'h8);
        tick();
        clr_req = 4'b0010; row_a[1] = 5'd8; col_a[1] = 5'd8;
        load_req = 1'b1; load_stage = 2'd2; bm_ready = 1'b1;
        #1;
        chk("t4_blocked_c3", 32'(clr_ack), 0);
        chk("t4_lack_c3", 32'(load_ack), 0);
        tick(); #1;
        chk("t4_en", 32'(bm_enable), 1);
        chk("t4_lack", 32'(load_ack), 1);
        chk("t4_func", 32'(bm_func), 32'(F_LOAD));
        chk("t4_stage", 32'(bm_stage), 2);
        chk("t4_blocked_c4", 32'(clr_ack), 0);
        tick(); load_req = 1'b0; clr_req = '0; #1;
        chk("t4_lack_c5", 32'(load_ack), 0);
        for (int c = 6; c <= 12; c++) begin
            tick(); #1;
            chk("t4_no_clear", 32'(bm_enable), 0);
        end
        chk("t4_busy_end", 32'(busy), 0);
        chk("t4_func_end", 32'(bm_func), 32'(F_LOAD));

        // Full FIFO blocks a new coordinate without moving the rr pointer
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick(); row_a[0] = 5'(k + 1); col_a[0] = 5'(k + 1); clr_req = 4'b0001; #1;
            chk("t5_ack_fill", 32'(clr_ack), 32'h1);
        end
        tick();
        row_a[0] = 5'd2; col_a[0] = 5'd2;
        row_a[1] = 5'd9; col_a[1] = 5'd9;
        clr_req = 4'b0011;
        #1;
        chk("t5_full_c4", 32'(clr_ack), 0);
        tick(); #1;
        chk("t5_full_c5", 32'(clr_ack), 0);
        tick(); bm_ready = 1'b1; #1;
        chk("t5_pop_c6", 32'(clr_ack), 0);
        chk("t5_en_c6", 32'(bm_enable), 0);
        tick(); #1;
        chk("t5_ack_c7", 32'(clr_ack), 32'h2);
        chk("t5_en_c7", 32'(bm_enable), 1);
        chk("t5_row_c7", 32'(bm_row), 1);
        chk("t5_col_c7", 32'(bm_col), 1);
        tick(); clr_req = '0; #1;
        chk("t5_ack_c8", 32'(clr_ack), 0);

        // Asynchronous reset during WAIT with entries still queued
        do_reset();
        row_a[0] = 5'd1; col_a[0] = 5'd1;
        row_a[1] = 5'd2; col_a[1] = 5'd2;
        row_a[2] = 5'd3; col_a[2] = 5'd3;
        tick(); clr_req = 4'b0111; #1;
        chk("t6_ack0", 32'(clr_ack), 32'h1);
        tick(); clr_req = 4'b0110; #1;
        chk("t6_ack1", 32'(clr_ack), 32'h2);
        tick(); clr_req = 4'b0100; #1;
        chk("t6_ack2", 32'(clr_ack), 32'h4);
        tick(); clr_req = '0; bm_ready = 1'b1; #1;
        chk("t6_en_c3", 32'(bm_enable), 0);
        tick(); bm_ready = 1'b0; #1;
        chk("t6_en_c4", 32'(bm_enable), 1);
        chk("t6_row_c4", 32'(bm_row), 1);
        tick(); #1;
        chk("t6_en_c5", 32'(bm_enable), 0);
        tick(); #1;
        chk("t6_busy_wait", 32'(busy), 1);
        chk("t6_func_wait", 32'(bm_func), 32'(F_CLEAR));
        tick(); reset = 1'b1; #1;
        chk("t6_rst_en", 32'(bm_enable), 0);
        chk("t6_rst_func", 32'(bm_func), 0);
        chk("t6_rst_row", 32'(bm_row), 0);
        chk("t6_rst_col", 32'(bm_col), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_cack", 32'(clr_ack), 0);
        tick(); reset = 1'b0; bm_ready = 1'b1; #1;
        for (int c = 0; c < 8; c++) begin
            tick(); #1;
            chk("t6_post_en", 32'(bm_enable), 0);
            chk("t6_post_busy", 32'(busy), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
